// File: rtl/rf_pkg.sv
// Shared defaults and slice helper for the multi-port register file.
package rf_pkg;

   localparam int unsigned RF_WL       = 32;
   localparam int unsigned RF_DEPTH    = 32;
   localparam int unsigned RF_NUM_READ = 2;

   // Bit offset of element `port` inside a packed vector of `width`-bit fields.
   function automatic int unsigned rf_port_sel(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Load-use scoreboard: per-register pending bits, outstanding-claim count and per-port lookup.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned NUM_READ = RF_NUM_READ,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         claim_en,
   input  logic [ADDR_W-1:0]            claim_addr,
   input  logic                         wrb_en,
   input  logic [ADDR_W-1:0]            wrb_addr,
   input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
   output logic [NUM_READ-1:0]          read_pending,
   output logic [ADDR_W:0]              pending_count
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DEPTH-1:0] pending_q, pending_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             claim_ok;
   logic             set_new;
   logic             clr_set;

   assign claim_ok = claim_en && !(ZERO_REG && (claim_addr == '0));
   assign set_new  = claim_ok && !pending_q[claim_addr];
   // A same-address claim keeps the bit set, so the clear does not count.
   assign clr_set  = wrb_en && pending_q[wrb_addr] && !(claim_ok && (claim_addr == wrb_addr));

   always_comb begin
      pending_d = pending_q;
      if (wrb_en) pending_d[wrb_addr] = 1'b0;
      if (claim_ok) pending_d[claim_addr] = 1'b1;
   end

   always_comb begin
      count_d = count_q;
      case ({set_new, clr_set})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign pending_count = count_q;

   for (genvar g = 0; g < NUM_READ; g++) begin : g_port
      logic [ADDR_W-1:0] ra;
      logic              retiring;

      assign ra       = read_addr[rf_port_sel(g, ADDR_W) +: ADDR_W];
      assign retiring = BYPASS && wrb_en && (wrb_addr == ra) && !(claim_ok && (claim_addr == ra));
      assign read_pending[g] = rst_n && pending_q[ra] && !retiring;
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ combinational reads, ALU (A) and load (B) write ports,
// optional zero register and write-to-read bypass, plus an integrated load-use scoreboard.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned WL       = RF_WL,
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter int unsigned ADDR_W   = $clog2(DEPTH),
   parameter int unsigned NUM_READ = RF_NUM_READ,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic [NUM_READ*ADDR_W-1:0] RF_Read_Address,
   output logic [NUM_READ*WL-1:0]     RF_Read_Data,
   output logic [NUM_READ-1:0]        RF_Read_Pending,
   input  logic                       RF_WrA_En,
   input  logic [ADDR_W-1:0]          RF_WrA_Address,
   input  logic [WL-1:0]              RF_WrA_Data,
   input  logic                       RF_WrB_En,
   input  logic [ADDR_W-1:0]          RF_WrB_Address,
   input  logic [WL-1:0]              RF_WrB_Data,
   input  logic                       RF_Claim_En,
   input  logic [ADDR_W-1:0]          RF_Claim_Address,
   output logic [ADDR_W:0]            RF_Pending_Count
);

   logic [WL-1:0] regs_q [DEPTH];
   logic          wa_ok;
   logic          wb_ok;

   assign wa_ok = RF_WrA_En && !(ZERO_REG && (RF_WrA_Address == '0));
   assign wb_ok = RF_WrB_En && !(ZERO_REG && (RF_WrB_Address == '0));

   // Port B is assigned last so it wins a same-address collision.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      end else begin
         if (wa_ok) regs_q[RF_WrA_Address] <= RF_WrA_Data;
         if (wb_ok) regs_q[RF_WrB_Address] <= RF_WrB_Data;
      end
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_read
      logic [ADDR_W-1:0] ra;
      logic [WL-1:0]     rd;

      assign ra = RF_Read_Address[rf_port_sel(g, ADDR_W) +: ADDR_W];

      always_comb begin
         rd = regs_q[ra];
         if (BYPASS) begin
            if (wa_ok && (RF_WrA_Address == ra)) rd = RF_WrA_Data;
            if (wb_ok && (RF_WrB_Address == ra)) rd = RF_WrB_Data;
         end
         // Reset also masks the bypass path so reads are 0 while it is held.
         if (!RST_N || (ZERO_REG && (ra == '0))) rd = '0;
      end

      assign RF_Read_Data[rf_port_sel(g, WL) +: WL] = rd;
   end

   rf_scoreboard #(
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .NUM_READ (NUM_READ),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk           (CLK),
      .rst_n         (RST_N),
      .claim_en      (RF_Claim_En),
      .claim_addr    (RF_Claim_Address),
      .wrb_en        (RF_WrB_En),
      .wrb_addr      (RF_WrB_Address),
      .read_addr     (RF_Read_Address),
      .read_pending  (RF_Read_Pending),
      .pending_count (RF_Pending_Count)
   );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: default, no-bypass and DEPTH=16/NUM_READ=4/no-zero-reg instances.
module tb_register_file_mp;

   logic clk;
   logic rst_n;

   // Default instance and BYPASS=0 instance share the same stimulus.
   logic [9:0]  rd_addr;
   logic [63:0] rd_data, rd_data_nb;
   logic [1:0]  rd_pend, rd_pend_nb;
   logic        wa_en, wb_en, cl_en;
   logic [4:0]  wa_a, wb_a, cl_a;
   logic [31:0] wa_d, wb_d;
   logic [5:0]  cnt, cnt_nb;

   logic [15:0]  s_rd_addr;
   logic [127:0] s_rd_data;
   logic [3:0]   s_rd_pend;
   logic         s_wa_en, s_wb_en, s_cl_en;
   logic [3:0]   s_wa_a, s_wb_a, s_cl_a;
   logic [31:0]  s_wa_d, s_wb_d;
   logic [4:0]   s_cnt;

   int checks   = 0;
   int failures = 0;

   register_file_mp dut (
      .CLK (clk), .RST_N (rst_n),
      .RF_Read_Address (rd_addr), .RF_Read_Data (rd_data), .RF_Read_Pending (rd_pend),
      .RF_WrA_En (wa_en), .RF_WrA_Address (wa_a), .RF_WrA_Data (wa_d),
      .RF_WrB_En (wb_en), .RF_WrB_Address (wb_a), .RF_WrB_Data (wb_d),
      .RF_Claim_En (cl_en), .RF_Claim_Address (cl_a), .RF_Pending_Count (cnt)
   );

   register_file_mp #(.BYPASS (1'b0)) dut_nb (
      .CLK (clk), .RST_N (rst_n),
      .RF_Read_Address (rd_addr), .RF_Read_Data (rd_data_nb), .RF_Read_Pending (rd_pend_nb),
      .RF_WrA_En (wa_en), .RF_WrA_Address (wa_a), .RF_WrA_Data (wa_d),
      .RF_WrB_En (wb_en), .RF_WrB_Address (wb_a), .RF_WrB_Data (wb_d),
      .RF_Claim_En (cl_en), .RF_Claim_Address (cl_a), .RF_Pending_Count (cnt_nb)
   );

   register_file_mp #(.DEPTH (16), .NUM_READ (4), .ZERO_REG (1'b0)) dut_sw (
      .CLK (clk), .RST_N (rst_n),
      .RF_Read_Address (s_rd_addr), .RF_Read_Data (s_rd_data), .RF_Read_Pending (s_rd_pend),
      .RF_WrA_En (s_wa_en), .RF_WrA_Address (s_wa_a), .RF_WrA_Data (s_wa_d),
      .RF_WrB_En (s_wb_en), .RF_WrB_Address (s_wb_a), .RF_WrB_Data (s_wb_d),
      .RF_Claim_En (s_cl_en), .RF_Claim_Address (s_cl_a), .RF_Pending_Count (s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        wa_en;
      logic [4:0]  wa_a;
      logic [31:0] wa_d;
      logic        wb_en;
      logic [4:0]  wb_a;
      logic [31:0] wb_d;
      logic        cl_en;
      logic [4:0]  cl_a;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [31:0] e_nb0;
      logic        e_p0;
      logic        e_p1;
      logic [5:0]  e_cnt;
   } vec_t;

   localparam int NVEC = 23;
   vec_t vecs [NVEC];

   function automatic vec_t mk(
      input logic ae, input logic [4:0] aa, input logic [31:0] ad,
      input logic be, input logic [4:0] ba, input logic [31:0] bd,
      input logic ce, input logic [4:0] ca, input logic [4:0] r0, input logic [4:0] r1,
      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] nb0,
      input logic p0, input logic p1, input logic [5:0] c);
      vec_t v;
      v.wa_en = ae; v.wa_a = aa; v.wa_d = ad;
      v.wb_en = be; v.wb_a = ba; v.wb_d = bd;
      v.cl_en = ce; v.cl_a = ca; v.r0 = r0; v.r1 = r1;
      v.e_d0 = d0; v.e_d1 = d1; v.e_nb0 = nb0;
      v.e_p0 = p0; v.e_p1 = p1; v.e_cnt = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_main();
      wa_en = 1'b0; wa_a = '0; wa_d = '0;
      wb_en = 1'b0; wb_a = '0; wb_d = '0;
      cl_en = 1'b0; cl_a = '0;
   endtask

   task automatic idle_sweep();
      s_wa_en = 1'b0; s_wa_a = '0; s_wa_d = '0;
      s_wb_en = 1'b0; s_wb_a = '0; s_wb_d = '0;
      s_cl_en = 1'b0; s_cl_a = '0;
      s_rd_addr = '0;
   endtask

   initial begin
      // Expectations are the combinational view before the edge that applies the vector.
      //                ae aa  ad            be ba  bd     ce ca  r0  r1  d0            d1            nb0           p0 p1 cnt
      vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0,     0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 0,            0, 0, 0);
      vecs[1]  = mk(0, 0,  0,            0, 0,  0,     0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
      vecs[2]  = mk(1, 0,  32'h1234,     0, 0,  0,     0, 0,  0,  5,  0,            32'hDEADBEEF, 0,            0, 0, 0);
      vecs[3]  = mk(0, 0,  0,            0, 0,  0,     0, 0,  0,  0,  0,            0,            0,            0, 0, 0);
      vecs[4]  = mk(1, 7,  32'h11,       1, 7,  32'h22, 0, 0,  7,  7,  32'h22,       32'h22,       0,            0, 0, 0);
      vecs[5]  = mk(0, 0,  0,            0, 0,  0,     0, 0,  7,  5,  32'h22,       32'hDEADBEEF, 32'h22,       0, 0, 0);
      vecs[6]  = mk(1, 6,  32'h66,       1, 8,  32'h88, 0, 0,  6,  8,  32'h66,       32'h88,       0,            0, 0, 0);
      vecs[7]  = mk(0, 0,  0,            0, 0,  0,     0, 0,  6,  8,  32'h66,       32'h88,       32'h66,       0, 0, 0);
      vecs[8]  = mk(0, 0,  0,            0, 0,  0,     1, 3,  3,  3,  0,            0,            0,            0, 0, 0);
      vecs[9]  = mk(0, 0,  0,            0, 0,  0,     1, 3,  3,  5,  0,            32'hDEADBEEF, 0,            1, 0, 1);
      vecs[10] = mk(0, 0,  0,            0, 0,  0,     0, 0,  3,  3,  0,            0,            0,            1, 1, 1);
      vecs[11] = mk(0, 0,  0,            1, 3,  32'h55, 0, 0,  3,  3,  32'h55,       32'h55,       0,            0, 0, 1);
      vecs[12] = mk(0, 0,  0,            0, 0,  0,     0, 0,  3,  3,  32'h55,       32'h55,       32'h55,       0, 0, 0);
      vecs[13] = mk(0, 0,  0,            0, 0,  0,     1, 4,  4,  4,  0,            0,            0,            0, 0, 0);
      vecs[14] = mk(0, 0,  0,            1, 4,  32'h44, 1, 4,  4,  4,  32'h44,       32'h44,       0,            1, 1, 1);
      vecs[15] = mk(0, 0,  0,            1, 4,  32'h45, 1, 9,  4,  9,  32'h45,       0,            32'h44,       0, 0, 1);
      vecs[16] = mk(0, 0,  0,            0, 0,  0,     0, 0,  4,  9,  32'h45,       0,            32'h45,       0, 1, 1);
      vecs[17] = mk(0, 0,  0,            0, 0,  0,     1, 0,  0,  9,  0,            0,            0,            0, 1, 1);
      vecs[18] = mk(0, 0,  0,            0, 0,  0,     0, 0,  0,  9,  0,            0,            0,            0, 1, 1);
      vecs[19] = mk(0, 0,  0,            1, 12, 32'hC, 0, 0,  12, 9,  32'hC,        0,            0,            0, 1, 1);
      vecs[20] = mk(0, 0,  0,            0, 0,  0,     0, 0,  12, 9,  32'hC,        0,            32'hC,        0, 1, 1);
      vecs[21] = mk(1, 1,  32'h1,        1, 0,  32'h99, 0, 0,  0,  1,  0,            32'h1,        0,            0, 0, 1);
      vecs[22] = mk(0, 0,  0,            0, 0,  0,     0, 0,  0,  1,  0,            32'h1,        0,            0, 0, 1);

      // Reset held with busy inputs: outputs must stay 0 even with bypass candidates present.
      rst_n = 1'b0;
      wa_en = 1'b1; wa_a = 5; wa_d = 32'hFFFF_FFFF;
      wb_en = 1'b1; wb_a = 3; wb_d = 32'h1357;
      cl_en = 1'b1; cl_a = 3;
      rd_addr = {5'd3, 5'd5};
      idle_sweep();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_hold data", rd_data, 64'h0);
      check("rst_hold pend", rd_pend, 2'b00);
      check("rst_hold cnt", cnt, 6'd0);
      idle_main();
      rst_n = 1'b1;
      #1;
      check("rst_rel data", rd_data, 64'h0);
      check("rst_rel pend", rd_pend, 2'b00);
      check("rst_rel cnt", cnt, 6'd0);
      check("rst_rel sw cnt", s_cnt, 5'd0);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         wa_en = vecs[i].wa_en; wa_a = vecs[i].wa_a; wa_d = vecs[i].wa_d;
         wb_en = vecs[i].wb_en; wb_a = vecs[i].wb_a; wb_d = vecs[i].wb_d;
         cl_en = vecs[i].cl_en; cl_a = vecs[i].cl_a;
         rd_addr = {vecs[i].r1, vecs[i].r0};
         #1;
         check($sformatf("v%0d d0", i), rd_data[31:0], vecs[i].e_d0);
         check($sformatf("v%0d d1", i), rd_data[63:32], vecs[i].e_d1);
         check($sformatf("v%0d nb_d0", i), rd_data_nb[31:0], vecs[i].e_nb0);
         check($sformatf("v%0d p0", i), rd_pend[0], vecs[i].e_p0);
         check($sformatf("v%0d p1", i), rd_pend[1], vecs[i].e_p1);
         check($sformatf("v%0d cnt", i), cnt, vecs[i].e_cnt);
      end

      // Asynchronous reset mid-run: state clears before any clock edge.
      @(negedge clk);
      idle_main();
      rd_addr = {5'd9, 5'd5};
      #1;
      check("pre_rst r5", rd_data[31:0], 32'hDEADBEEF);
      check("pre_rst p9", rd_pend[1], 1'b1);
      check("pre_rst cnt", cnt, 6'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst r5", rd_data[31:0], 32'h0);
      check("mid_rst p9", rd_pend[1], 1'b0);
      check("mid_rst cnt", cnt, 6'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst r5", rd_data[31:0], 32'h0);
      check("post_rst p9", rd_pend[1], 1'b0);
      check("post_rst cnt", cnt, 6'd0);

      // Sweep instance: r0 is an ordinary register, and all 16 can be claimed.
      @(negedge clk);
      s_wa_en = 1'b1; s_wa_a = 0; s_wa_d = 32'hA5;
      s_rd_addr = {4'd0, 4'd0, 4'd0, 4'd0};
      #1;
      check("sw r0 bypass", s_rd_data[31:0], 32'hA5);
      @(negedge clk);
      idle_sweep();
      #1;
      check("sw r0 p0", s_rd_data[31:0], 32'hA5);
      check("sw r0 p3", s_rd_data[127:96], 32'hA5);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         s_cl_en = 1'b1; s_cl_a = 4'(k);
      end
      @(negedge clk);
      s_cl_en = 1'b0;
      s_rd_addr = {4'd15, 4'd10, 4'd5, 4'd0};
      #1;
      check("sw cnt full", s_cnt, 5'd16);
      check("sw pend all", s_rd_pend, 4'b1111);
      s_cl_en = 1'b1; s_cl_a = 4'd7;
      @(negedge clk);
      s_cl_en = 1'b0;
      s_wb_en = 1'b1; s_wb_a = 4'd2; s_wb_d = 32'h2222;
      #1;
      check("sw cnt reclaim", s_cnt, 5'd16);
      @(negedge clk);
      idle_sweep();
      s_rd_addr = {4'd2, 4'd2, 4'd2, 4'd2};
      #1;
      check("sw cnt clear", s_cnt, 5'd15);
      check("sw r2 pend", s_rd_pend, 4'b0000);
      check("sw r2 data", s_rd_data[95:64], 32'h2222);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-cycle register file, for the pipelined datapath.
- Provides NUM_READ combinational read ports and two synchronous write ports: port A for ALU writeback, port B for load writeback.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Integrated load-use scoreboard: per-register pending bits plus an outstanding-claim counter, consumed by the hazard unit.

Parameters:
- WL, 32, data word width.
- DEPTH, 32, number of registers (power of two, 2..64).
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_READ, 2, number of read ports (1..4).
- BYPASS, 1, 1 = write data forwarded to reads in the same cycle.
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and claims.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- RF_Read_Address  in  NUM_READ*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- RF_Read_Data  out  NUM_READ*WL  packed read data, port i = [i*WL +: WL].
- RF_Read_Pending  out  NUM_READ  1 = register addressed by port i has an outstanding load.
- RF_WrA_En  in  1  port A write enable.
- RF_WrA_Address  in  ADDR_W  port A write address.
- RF_WrA_Data  in  WL  port A write data.
- RF_WrB_En  in  1  port B (load) write enable; also clears the pending bit.
- RF_WrB_Address  in  ADDR_W  port B write address.
- RF_WrB_Data  in  WL  port B write data.
- RF_Claim_En  in  1  load issued; mark destination pending.
- RF_Claim_Address  in  ADDR_W  destination register of the issued load.
- RF_Pending_Count  out  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All registers are 0, all pending bits are 0, RF_Pending_Count = 0.
  - Therefore every RF_Read_Data is 0 and every RF_Read_Pending is 0 while reset is held.
  - Reset asserted mid-operation discards any in-flight writes and claims immediately.
- Writes:
  - A register is updated at the rising edge when its port enable is 1.
  - A and B to the same address in the same cycle: B wins.
  - A and B to different addresses: both are written.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads:
  - Combinational, zero latency; all ports are independent, and duplicate addresses are allowed.
  - BYPASS=1: if a write enable is 1 and its address equals the read address (and is not 0 when ZERO_REG=1), the read returns that write's data. B takes priority over A.
  - BYPASS=0: a read returns the pre-edge register contents.
  - ZERO_REG=1: address 0 always reads 0.
- Scoreboard:
  - Claim sets pending[RF_Claim_Address] at the edge.
  - A port B write clears pending[RF_WrB_Address] at the edge. Port A never touches pending bits.
  - Claim and B write to the same address in the same cycle: the bit stays set (the new load wins).
  - Claim of an already-pending register: no change.
  - Claim of address 0 with ZERO_REG=1: ignored.
  - B write to a non-pending register: the data is written; pending bits and the count are unchanged.
- RF_Read_Pending[i]:
  - Equals pending[addr_i].
  - With BYPASS=1 it is forced to 0 when a B write to the same address is occurring this cycle and there is no same-cycle claim to that address.
- RF_Pending_Count: next = count + (claim sets a new bit) − (B write clears a set bit).
  - A simultaneous set and clear on different addresses leaves the count unchanged.
  - Count never exceeds DEPTH (or DEPTH−1 with ZERO_REG=1).
  - Count never underflows.

Decomposition:
- Package rf_pkg:
  - Default constants RF_WL=32, RF_DEPTH=32, RF_NUM_READ=2.
  - Function rf_port_sel for packed-slice indexing.
- Sub-module rf_scoreboard: pending-bit vector, pending counter, per-port pending lookup.
- Storage array and bypass muxes stay in the top-level module.

Test Plan:
- Reset: hold RST_N=0 with arbitrary inputs, then release → all reads 0, RF_Read_Pending=0, count=0. Pulse RST_N low mid-run → all state is 0 immediately, without waiting for a clock edge.
- Write/read: write A r5=0xDEADBEEF, next cycle read r5 on ports 0 and 1 → both 0xDEADBEEF. Write A r0=0x1234 → r0 reads 0.
- Collision and bypass: same cycle, A r7=0x11 and B r7=0x22 with read r7 →
  - BYPASS=1: 0x22 that cycle.
  - BYPASS=0: old value that cycle.
  - Both: 0x22 afterwards.
- Scoreboard: claim r3 → next cycle RF_Read_Pending (reading r3) = 1, count=1. Claim r3 again → count still 1. B write r3=0x55 → pending is 0 in the same cycle (BYPASS=1), count=0 after the edge.
- Simultaneous claim and clear: r4 pending; same cycle claim r4 and B write r4 → r4 stays pending, count=1. Same cycle claim r9 and B write r4 → count unchanged at 1, r9 pending, r4 clear.
- Parameter sweep: DEPTH=16, NUM_READ=4, ZERO_REG=0 → r0 is writable (write 0xA5, read 0xA5). Claim all 16 registers → count=16, with no overflow.
